box_readback: RTL and testbench

Reads back a square region of the 160x120 video memory in the same row-major order the box drawer writes it, and reports whether any pixel in the region differs from the background colour. Used by the game logic for collision checks before moving a box. Sits beside the VGA adapter on the framebuffer's read port. Issues one read per cycle and returns a hit summary with a one-cycle `done` pulse.

---
 rtl/box_readback_pkg.sv | 19 +
 rtl/box_scan_counter.sv | 57 +++++
 rtl/box_readback.sv | 145 ++++++++++++++
 tb/tb_box_readback.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/box_readback_pkg.sv
// Shared screen geometry, colour/address widths and FSM encoding for the box readback
// and box drawer blocks.
package box_readback_pkg;

  localparam int VGA_SCREEN_W = 160;
  localparam int VGA_SCREEN_H = 120;
  localparam int ADDR_W       = 15;
  localparam int COL_W        = 3;

  localparam logic [COL_W-1:0] VGA_BG_COLOUR = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/box_scan_counter.sv
// Row-major cx/cy walker over a size x size box; px/py are registered absolute coordinates,
// one pixel per step, no stall input (the caller simply withholds step).
module box_scan_counter #(
  parameter int SIZE_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [7:0]        base_x_i,
  input  logic [6:0]        base_y_i,
  input  logic [SIZE_W-1:0] size_i,
  output logic [8:0]        px_o,
  output logic [7:0]        py_o,
  output logic              last_o
);

  logic [SIZE_W-1:0] cx_q, cy_q, size_q, edge_m1;
  logic [7:0]        bx_q;
  logic [8:0]        px_q;
  logic [7:0]        py_q;

  assign edge_m1 = size_q - SIZE_W'(1);
  assign last_o  = (cx_q == edge_m1) && (cy_q == edge_m1);
  assign px_o    = px_q;
  assign py_o    = py_q;

  // px/py are kept one bit wider than the screen so a box hanging off the edge never wraps.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cx_q   <= '0;
      cy_q   <= '0;
      size_q <= '0;
      bx_q   <= '0;
      px_q   <= '0;
      py_q   <= '0;
    end else if (load_i) begin
      cx_q   <= '0;
      cy_q   <= '0;
      size_q <= size_i;
      bx_q   <= base_x_i;
      px_q   <= {1'b0, base_x_i};
      py_q   <= {1'b0, base_y_i};
    end else if (step_i) begin
      if (cx_q == edge_m1) begin
        cx_q <= '0;
        cy_q <= cy_q + SIZE_W'(1);
        px_q <= {1'b0, bx_q};
        py_q <= py_q + 8'd1;
      end else begin
        cx_q <= cx_q + SIZE_W'(1);
        px_q <= px_q + 9'd1;
      end
    end
  end

endmodule

// File: rtl/box_readback.sv
// Reads a square framebuffer region row-major, one read/cycle, and reports non-background hits;
// done pulses size^2+2 cycles after start (1 for size 0); start is only taken while ready.
module box_readback
  import box_readback_pkg::*;
#(
  parameter int               SIZE_W    = 4,
  parameter int               SCREEN_W  = VGA_SCREEN_W,
  parameter int               SCREEN_H  = VGA_SCREEN_H,
  parameter logic [COL_W-1:0] BG_COLOUR = VGA_BG_COLOUR
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [7:0]            givex,
  input  logic [6:0]            givey,
  input  logic [SIZE_W-1:0]     size,
  output logic                  ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_rd_en,
  input  logic [COL_W-1:0]      mem_rdata,
  output logic                  done,
  output logic                  hit,
  output logic [2*SIZE_W-1:0]   hit_count,
  output logic [7:0]            hit_x,
  output logic [6:0]            hit_y
);

  localparam int         CNT_W  = 2 * SIZE_W;
  localparam logic [8:0] SCR_W9 = 9'(SCREEN_W);
  localparam logic [7:0] SCR_H8 = 8'(SCREEN_H);

  state_t           state_q, state_d;
  logic             accept, step, last, in_screen;
  logic [8:0]       px;
  logic [7:0]       py;
  logic             rvld_q;
  logic [7:0]       rpx_q;
  logic [6:0]       rpy_q;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       hx_q, hx_d;
  logic [6:0]       hy_q, hy_d;

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    step    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = (size == '0) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        step = 1'b1;
        if (last) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  box_scan_counter #(.SIZE_W(SIZE_W)) u_scan (
    .clk_i    (clock),
    .rst_n_i  (resetn),
    .load_i   (accept),
    .step_i   (step),
    .base_x_i (givex),
    .base_y_i (givey),
    .size_i   (size),
    .px_o     (px),
    .py_o     (py),
    .last_o   (last)
  );

  // Clipped pixels still spend their cycle so latency never depends on position.
  assign in_screen = (px < SCR_W9) && (py < SCR_H8);
  assign mem_rd_en = (state_q == ST_SCAN) && in_screen;
  assign mem_addr  = mem_rd_en ? (ADDR_W'(py) * ADDR_W'(SCREEN_W) + ADDR_W'(px)) : '0;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rvld_q <= 1'b0;
      rpx_q  <= '0;
      rpy_q  <= '0;
    end else begin
      rvld_q <= mem_rd_en;
      rpx_q  <= px[7:0];
      rpy_q  <= py[6:0];
    end
  end

  always_comb begin
    hit_d = hit_q;
    cnt_d = cnt_q;
    hx_d  = hx_q;
    hy_d  = hy_q;
    if (accept) begin
      hit_d = 1'b0;
      cnt_d = '0;
      hx_d  = '0;
      hy_d  = '0;
    end else if (rvld_q && (mem_rdata != BG_COLOUR)) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (!hit_q) begin
        hit_d = 1'b1;
        hx_d  = rpx_q;
        hy_d  = rpy_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      hit_q <= 1'b0;
      cnt_q <= '0;
      hx_q  <= '0;
      hy_q  <= '0;
    end else begin
      hit_q <= hit_d;
      cnt_q <= cnt_d;
      hx_q  <= hx_d;
      hy_q  <= hy_d;
    end
  end

  assign hit       = hit_q;
  assign hit_count = cnt_q;
  assign hit_x     = hx_q;
  assign hit_y     = hy_q;

endmodule

// File: tb/tb_box_readback.sv
// Directed table-driven bench for box_readback with a one-cycle-latency framebuffer model.
module tb_box_readback;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  givex = '0;
  logic [6:0]  givey = '0;
  logic [3:0]  size = '0;
  logic        ready, mem_rd_en, done, hit;
  logic [14:0] mem_addr;
  logic [2:0]  mem_rdata = 3'b111;
  logic [7:0]  hit_count, hit_x;
  logic [6:0]  hit_y;

  always #5 clock = ~clock;

  box_readback #(.SIZE_W(4)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .givex     (givex),
    .givey     (givey),
    .size      (size),
    .ready     (ready),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .done      (done),
    .hit       (hit),
    .hit_count (hit_count),
    .hit_x     (hit_x),
    .hit_y     (hit_y)
  );

  logic [2:0] mem [0:19199];

  // Data appears the cycle after the strobe; non-strobed cycles return a non-BG value.
  always @(posedge clock) begin
    if (mem_rd_en && mem_addr < 15'd19200) mem_rdata <= mem[mem_addr];
    else                                   mem_rdata <= 3'b111;
  end

  int passes = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 19200; i++) mem[i] = 3'b000;
  endtask

  task automatic set_px(input int x, input int y, input logic [2:0] c);
    mem[y * 160 + x] = c;
  endtask

  typedef struct {
    int gx, gy, sz;
    int nh;
    int h0x, h0y, h1x, h1y;
    bit fill;
    int exp_done, exp_reads, exp_hit, exp_cnt, exp_hx, exp_hy;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input vec_t v, input int pulse_off, input string tag);
    int done_off, reads, bad, k, epx, epy;
    int r_hit, r_cnt, r_hx, r_hy;
    logic exp_en;
    logic [14:0] exp_a;
    clear_mem();
    if (v.fill)
      for (int y = 0; y < v.sz; y++)
        for (int x = 0; x < v.sz; x++) set_px(v.gx + x, v.gy + y, 3'b101);
    if (v.nh > 0) set_px(v.h0x, v.h0y, 3'b100);
    if (v.nh > 1) set_px(v.h1x, v.h1y, 3'b011);
    @(negedge clock);
    givex = 8'(v.gx);
    givey = 7'(v.gy);
    size  = 4'(v.sz);
    start = 1'b1;
    done_off = -1; reads = 0; bad = 0;
    r_hit = -1; r_cnt = -1; r_hx = -1; r_hy = -1;
    for (int off = 1; off <= 300 && done_off < 0; off++) begin
      @(negedge clock);
      if (off == 1) chk({tag, "_ready_low"}, int'(ready), 0);
      k = off - 1;
      exp_en = 1'b0;
      exp_a  = '0;
      if (k < v.sz * v.sz) begin
        epx = v.gx + k % v.sz;
        epy = v.gy + k / v.sz;
        if (epx < 160 && epy < 120) begin
          exp_en = 1'b1;
          exp_a  = 15'(epy * 160 + epx);
        end
      end
      if (mem_rd_en !== exp_en || (exp_en && mem_addr !== exp_a)) bad++;
      if (mem_rd_en === 1'b1) reads++;
      if (done === 1'b1) begin
        done_off = off;
        r_hit = int'(hit); r_cnt = int'(hit_count);
        r_hx  = int'(hit_x); r_hy = int'(hit_y);
      end
      if (off == 1) start = 1'b0;
      if (off == pulse_off) begin
        start = 1'b1;
        givex = 8'd50;
      end
      if (off == pulse_off + 1) start = 1'b0;
    end
    chk({tag, "_done_cycle"}, done_off, v.exp_done);
    chk({tag, "_reads"}, reads, v.exp_reads);
    chk({tag, "_addr_seq_errors"}, bad, 0);
    chk({tag, "_hit"}, r_hit, v.exp_hit);
    chk({tag, "_hit_count"}, r_cnt, v.exp_cnt);
    chk({tag, "_hit_x"}, r_hx, v.exp_hx);
    chk({tag, "_hit_y"}, r_hy, v.exp_hy);
    @(negedge clock);
    chk({tag, "_ready_done_after"}, int'({ready, done}), 2);
    chk({tag, "_hold_count"}, int'(hit_count), v.exp_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ndone;
    //          gx  gy  sz nh h0x h0y h1x h1y fill done reads hit cnt hx  hy
    vecs[0] = '{ 10, 20, 4, 0,  0,  0,  0,  0, 0,  18,  16,  0,  0,  0,  0};
    vecs[1] = '{ 10, 20, 4, 1, 12, 21,  0,  0, 0,  18,  16,  1,  1, 12, 21};
    vecs[2] = '{ 10, 20, 4, 2, 11, 22, 13, 20, 0,  18,  16,  1,  2, 13, 20};
    vecs[3] = '{158,118, 4, 1,159,119,  0,  0, 0,  18,   4,  1,  1,159,119};
    vecs[4] = '{ 10, 20, 0, 1, 10, 20,  0,  0, 0,   1,   0,  0,  0,  0,  0};
    vecs[5] = '{  0,  0,15, 2, 14, 14,  5,  3, 0, 227, 225,  1,  2,  5,  3};
    vecs[6] = '{100, 50, 3, 0,  0,  0,  0,  0, 1,  11,   9,  1,  9,100, 50};

    clear_mem();
    repeat (3) @(negedge clock);
    chk("reset_ready", int'(ready), 1);
    chk("reset_rd_en", int'(mem_rd_en), 0);
    chk("reset_addr", int'(mem_addr), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_hit", int'(hit), 0);
    chk("reset_count", int'(hit_count), 0);
    chk("reset_hit_x", int'(hit_x), 0);
    chk("reset_hit_y", int'(hit_y), 0);
    resetn = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], 0, $sformatf("vec%0d", i));

    // Start pulsed mid-scan with a different origin must leave the result untouched.
    run_vec(vecs[1], 5, "ignored_start");

    // Reset asserted in cycle T+5 after an early hit has already been captured.
    clear_mem();
    set_px(10, 20, 3'b010);
    @(negedge clock);
    givex = 8'd10; givey = 7'd20; size = 4'd4; start = 1'b1;
    for (int off = 1; off <= 5; off++) begin
      @(negedge clock);
      if (off == 1) start = 1'b0;
    end
    chk("pre_reset_hit", int'(hit), 1);
    resetn = 1'b0;
    @(negedge clock);
    chk("midrst_ready", int'(ready), 1);
    chk("midrst_rd_en", int'(mem_rd_en), 0);
    chk("midrst_addr", int'(mem_addr), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_hit", int'(hit), 0);
    chk("midrst_count", int'(hit_count), 0);
    chk("midrst_hit_x", int'(hit_x), 0);
    chk("midrst_hit_y", int'(hit_y), 0);
    resetn = 1'b1;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (done !== 1'b0) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    run_vec(vecs[1], 0, "post_reset");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
